snitch_shared_acc_arbiter: RTL and testbench

- Shares one offloaded MUL/DIV accelerator between NrCores Snitch cores. The cores issue the instructions selected by `shared_offload`.
- Per-core accelerator request streams (`acc_req_t`) are arbitrated round-robin onto a single accelerator port.
- Responses (`acc_resp_t`) return in order and are routed back to the originating core through an in-order tag queue.
- Sits in the tile, between the core accelerator interfaces and the shared multiplier/divider.

---
 rtl/snitch_shared_acc_arbiter_pkg.sv | 32 +++
 rtl/snitch_shared_acc_arbiter_fifo.sv | 66 ++++++
 rtl/snitch_shared_acc_arbiter.sv | 141 ++++++++++++++
 tb/tb_snitch_shared_acc_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snitch_shared_acc_arbiter_pkg.sv
// Shared types for the tile-level accelerator sharing logic.
// Provides the accelerator request/response payload layouts, the default
// number of requests that may be in flight at the shared MUL/DIV unit, and
// a helper that sizes core-index fields.
package snitch_shared_acc_arbiter_pkg;

  localparam int unsigned NrSharedAccOutstanding = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [4:0]  id;
    logic [31:0] data_op;
    logic [31:0] data_arga;
    logic [31:0] data_argb;
    logic [31:0] data_argc;
  } acc_req_t;

  typedef struct packed {
    logic [4:0]  id;
    logic        error;
    logic [31:0] data;
  } acc_resp_t;

  localparam int unsigned AccReqWidth  = $bits(acc_req_t);
  localparam int unsigned AccRespWidth = $bits(acc_resp_t);

  // Width needed to index num items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num);
    return (num > 32'd1) ? unsigned'($clog2(num)) : 32'd1;
  endfunction

endpackage

// File: rtl/snitch_shared_acc_arbiter_fifo.sv
// In-order routing queue holding the index of the core that owns each
// request currently in flight at the shared accelerator.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   push_i/data_i  enqueue a core index (ignored when full)
//   pop_i          dequeue the head (ignored when empty)
//   data_o         head entry, valid while !empty_o
//   full_o/empty_o occupancy flags, derived purely from the count register
module snitch_shared_acc_arbiter_fifo #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);

  typedef logic [PtrWidth-1:0] ptr_t;

  logic [DataWidth-1:0] r_mem [Depth];
  ptr_t                 r_wr_ptr;
  ptr_t                 r_rd_ptr;
  logic [CntWidth-1:0]  r_count;
  logic                 w_push;
  logic                 w_pop;

  // Pointers wrap explicitly so Depth need not be a power of two.
  function automatic ptr_t wrap_inc(input ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (r_count == CntWidth'(Depth));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= wrap_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= wrap_inc(r_rd_ptr);
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/snitch_shared_acc_arbiter.sv
// Shares one offloaded MUL/DIV accelerator between NrCores cores.
// Requests are granted round-robin onto the single accelerator port; the
// granted core index is queued so in-order responses route back to it.
// Ports:
//   clk_i, rst_i                               clock, synchronous active-high reset
//   core_qvalid_i/core_qready_o/core_req_i     per-core request streams
//   core_pvalid_o/core_pready_i/core_resp_o    per-core response streams
//   acc_qvalid_o/acc_qready_i/acc_req_o        request port to the accelerator
//   acc_pvalid_i/acc_pready_o/acc_resp_i       response port from the accelerator
//   busy_o                                     at least one request in flight
module snitch_shared_acc_arbiter
  import snitch_shared_acc_arbiter_pkg::*;
#(
  parameter int unsigned NrCores        = 4,
  parameter int unsigned MaxOutstanding = NrSharedAccOutstanding,
  parameter int unsigned CoreIdxWidth   = idx_width(NrCores)
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NrCores-1:0]              core_qvalid_i,
  output logic [NrCores-1:0]              core_qready_o,
  input  logic [NrCores*AccReqWidth-1:0]  core_req_i,
  output logic [NrCores-1:0]              core_pvalid_o,
  input  logic [NrCores-1:0]              core_pready_i,
  output logic [NrCores*AccRespWidth-1:0] core_resp_o,
  output logic                            acc_qvalid_o,
  input  logic                            acc_qready_i,
  output logic [AccReqWidth-1:0]          acc_req_o,
  input  logic                            acc_pvalid_i,
  output logic                            acc_pready_o,
  input  logic [AccRespWidth-1:0]         acc_resp_i,
  output logic                            busy_o
);

  typedef logic [CoreIdxWidth-1:0] core_idx_t;

  core_idx_t r_rr;
  core_idx_t r_lock_idx;
  logic      r_locked;

  core_idx_t w_rr_idx;
  core_idx_t w_grant;
  core_idx_t w_head;
  logic      w_rr_found;
  logic      w_full;
  logic      w_empty;
  logic      w_offer;
  logic      w_q_hs;
  logic      w_p_valid;
  logic      w_p_hs;
  logic      w_head_pready;
  acc_req_t  w_req;
  acc_resp_t w_resp;

  // Round-robin: lowest valid index at or above r_rr, else lowest valid overall.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int unsigned i = 0; i < NrCores; i++) begin
      if (!w_rr_found && core_qvalid_i[i] && (core_idx_t'(i) >= r_rr)) begin
        w_rr_found = 1'b1;
        w_rr_idx   = core_idx_t'(i);
      end
    end
    for (int unsigned i = 0; i < NrCores; i++) begin
      if (!w_rr_found && core_qvalid_i[i]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = core_idx_t'(i);
      end
    end
  end

  // A stalled offer keeps its grant so acc_req_o cannot change under the accelerator.
  assign w_grant   = r_locked ? r_lock_idx : w_rr_idx;
  assign w_offer   = ~w_full & (r_locked | w_rr_found);
  assign w_q_hs    = w_offer & acc_qready_i;
  assign w_p_valid = acc_pvalid_i & ~w_empty;
  assign w_p_hs    = w_p_valid & acc_pready_o;

  always_comb begin
    w_req         = '0;
    core_qready_o = '0;
    core_pvalid_o = '0;
    w_head_pready = 1'b0;
    for (int unsigned i = 0; i < NrCores; i++) begin
      if (core_idx_t'(i) == w_grant) begin
        w_req            = acc_req_t'(core_req_i[i*AccReqWidth +: AccReqWidth]);
        core_qready_o[i] = w_q_hs;
      end
      if (core_idx_t'(i) == w_head) begin
        w_head_pready    = core_pready_i[i];
        core_pvalid_o[i] = w_p_valid;
      end
    end
  end

  assign w_resp       = w_p_valid ? acc_resp_t'(acc_resp_i) : '0;
  assign acc_qvalid_o = w_offer;
  assign acc_req_o    = w_offer ? w_req : '0;
  assign acc_pready_o = w_head_pready & ~w_empty;
  assign core_resp_o  = {NrCores{w_resp}};
  assign busy_o       = ~w_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr       <= '0;
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_q_hs) begin
      r_rr     <= (w_grant == core_idx_t'(NrCores - 1)) ? '0 : w_grant + 1'b1;
      r_locked <= 1'b0;
    end else if (w_offer) begin
      r_locked   <= 1'b1;
      r_lock_idx <= w_grant;
    end
  end

  // Full flag comes from the count register, so a same-cycle pop never frees a slot.
  snitch_shared_acc_arbiter_fifo #(
    .Depth     (MaxOutstanding),
    .DataWidth (CoreIdxWidth)
  ) i_route_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_q_hs),
    .data_i  (w_grant),
    .pop_i   (w_p_hs),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Protocol checks: a locked requester must keep qvalid; responses need an owner.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(r_locked && !core_qvalid_i[r_lock_idx]));
      assert (!(acc_pvalid_i && w_empty));
    end
  end

endmodule

// File: tb/tb_snitch_shared_acc_arbiter.sv
module tb_snitch_shared_acc_arbiter;

  localparam int N      = 4;
  localparam int MaxOut = 4;
  localparam int RW     = 165;
  localparam int PW     = 38;

  logic            clk = 1'b0;
  logic            rst_i;
  logic [N-1:0]    core_qvalid_i;
  logic [N-1:0]    core_qready_o;
  logic [N*RW-1:0] core_req_i;
  logic [N-1:0]    core_pvalid_o;
  logic [N-1:0]    core_pready_i;
  logic [N*PW-1:0] core_resp_o;
  logic            acc_qvalid_o;
  logic            acc_qready_i;
  logic [RW-1:0]   acc_req_o;
  logic            acc_pvalid_i;
  logic            acc_pready_o;
  logic [PW-1:0]   acc_resp_i;
  logic            busy_o;

  always #5 clk = ~clk;

  snitch_shared_acc_arbiter #(
    .NrCores        (N),
    .MaxOutstanding (MaxOut)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .core_qvalid_i (core_qvalid_i),
    .core_qready_o (core_qready_o),
    .core_req_i    (core_req_i),
    .core_pvalid_o (core_pvalid_o),
    .core_pready_i (core_pready_i),
    .core_resp_o   (core_resp_o),
    .acc_qvalid_o  (acc_qvalid_o),
    .acc_qready_i  (acc_qready_i),
    .acc_req_o     (acc_req_o),
    .acc_pvalid_i  (acc_pvalid_i),
    .acc_pready_o  (acc_pready_o),
    .acc_resp_i    (acc_resp_i),
    .busy_o        (busy_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: pending requests per core, rr pointer, held offer, owner queue.
  logic [RW-1:0] payload [N];
  bit            want    [N];
  bit            sticky;
  int            m_rr;
  int            m_hold;
  int            m_q [$];
  int            g_exp;
  bit            exp_push;
  bit            exp_pop;
  int            obs_log [$];

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] rnd_req();
    return {32'($urandom), 5'($urandom), 32'($urandom), 32'($urandom), 32'($urandom),
            32'($urandom)};
  endfunction

  function automatic logic [PW-1:0] rnd_resp();
    return {6'($urandom), 32'($urandom)};
  endfunction

  task automatic drive_check();
    int head;
    for (int i = 0; i < N; i++) begin
      core_qvalid_i[i]          = want[i];
      core_req_i[i*RW +: RW]    = payload[i];
    end
    #1;
    g_exp = -1;
    if (m_q.size() < MaxOut) begin
      if (m_hold >= 0) g_exp = m_hold;
      else begin
        for (int k = 0; k < N; k++) begin
          if (want[(m_rr + k) % N]) begin
            g_exp = (m_rr + k) % N;
            break;
          end
        end
      end
    end
    chk("acc_qvalid", acc_qvalid_o, g_exp >= 0);
    if (g_exp >= 0) chk("acc_req", acc_req_o, payload[g_exp]);
    exp_push = (g_exp >= 0) && acc_qready_i;
    chk("core_qready", core_qready_o, exp_push ? (1 << g_exp) : 0);
    head = (m_q.size() != 0) ? m_q[0] : -1;
    chk("core_pvalid", core_pvalid_o, (head >= 0 && acc_pvalid_i) ? (1 << head) : 0);
    chk("acc_pready", acc_pready_o, (head >= 0) ? core_pready_i[head] : 1'b0);
    exp_pop = (head >= 0) && acc_pvalid_i && core_pready_i[head];
    if (head >= 0 && acc_pvalid_i) chk("core_resp", core_resp_o[head*PW +: PW], acc_resp_i);
    chk("busy", busy_o, m_q.size() != 0);
    for (int i = 0; i < N; i++) if (core_qready_o[i]) obs_log.push_back(i);
  endtask

  task automatic advance();
    @(posedge clk);
    #2;
    if (exp_pop) void'(m_q.pop_front());
    if (exp_push) begin
      m_q.push_back(g_exp);
      m_rr   = (g_exp + 1) % N;
      m_hold = -1;
      if (!sticky) want[g_exp] = 1'b0;
    end else if (g_exp >= 0) begin
      m_hold = g_exp;
    end
  endtask

  task automatic cycle();
    drive_check();
    advance();
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) want[i] = 1'b0;
    core_qvalid_i = '0;
    acc_qready_i  = 1'b0;
    acc_pvalid_i  = 1'b0;
    core_pready_i = '0;
    acc_resp_i    = '0;
    rst_i         = 1'b1;
    @(posedge clk);
    #2;
    rst_i  = 1'b0;
    m_q.delete();
    m_rr   = 0;
    m_hold = -1;
    sticky = 1'b0;
    #1;
    chk("rst_acc_qvalid", acc_qvalid_o, 0);
    chk("rst_acc_req", acc_req_o, 0);
    chk("rst_core_qready", core_qready_o, 0);
    chk("rst_core_pvalid", core_pvalid_o, 0);
    chk("rst_core_resp", core_resp_o, 0);
    chk("rst_acc_pready", acc_pready_o, 0);
    chk("rst_busy", busy_o, 0);
  endtask

  task automatic drain();
    acc_qready_i  = 1'b0;
    core_pready_i = '1;
    for (int k = 0; k < 3 * MaxOut && m_q.size() != 0; k++) begin
      acc_pvalid_i = 1'b1;
      acc_resp_i   = rnd_resp();
      cycle();
    end
    acc_pvalid_i = 1'b0;
    #1;
    chk("drain_busy", busy_o, 0);
  endtask

  initial begin
    logic [RW-1:0] p1;
    int            order [3];
    int            cnt   [N];
    order = '{0, 2, 1};
    rst_i         = 1'b1;
    core_qvalid_i = '0;
    core_req_i    = '0;
    core_pready_i = '0;
    acc_qready_i  = 1'b0;
    acc_pvalid_i  = 1'b0;
    acc_resp_i    = '0;
    for (int i = 0; i < N; i++) begin
      payload[i] = '0;
      want[i]    = 1'b0;
    end
    do_reset();

    // Single request from core 2, MUL, id 5; response 3 cycles later.
    acc_qready_i  = 1'b1;
    core_pready_i = '1;
    payload[2]    = {32'h0000_1000, 5'd5, 32'h0200_0033, 32'd3, 32'd7, 32'd0};
    want[2]       = 1'b1;
    drive_check();
    chk("t1_grant", core_qready_o, 4'b0100);
    chk("t1_req_id", acc_req_o[132:128], 5'd5);
    advance();
    acc_qready_i = 1'b0;
    cycle();
    cycle();
    acc_pvalid_i = 1'b1;
    acc_resp_i   = {5'd5, 1'b0, 32'h0000_0015};
    drive_check();
    chk("t1_pvalid", core_pvalid_o, 4'b0100);
    chk("t1_data", core_resp_o[2*PW +: 32], 32'h15);
    chk("t1_id", core_resp_o[2*PW+33 +: 5], 5'd5);
    advance();
    acc_pvalid_i = 1'b0;
    #1;
    chk("t1_busy_clear", busy_o, 0);

    // Fairness: all cores always valid, accelerator always ready.
    do_reset();
    sticky = 1'b1;
    for (int i = 0; i < N; i++) begin
      want[i]    = 1'b1;
      payload[i] = rnd_req();
      cnt[i]     = 0;
    end
    acc_qready_i  = 1'b1;
    core_pready_i = '1;
    obs_log.delete();
    for (int k = 0; k < 100 && obs_log.size() < 40; k++) begin
      acc_pvalid_i = (m_q.size() != 0);
      acc_resp_i   = rnd_resp();
      cycle();
    end
    chk("fair_count", obs_log.size(), 40);
    for (int i = 0; i < 40 && i < obs_log.size(); i++) begin
      chk("fair_order", obs_log[i], i % N);
      cnt[obs_log[i]]++;
    end
    for (int i = 0; i < N; i++) chk("fair_share", cnt[i], 10);
    sticky = 1'b0;
    for (int i = 0; i < N; i++) want[i] = 1'b0;
    drain();

    // Back-pressure lock: core 1 held while core 0 joins mid-stall.
    p1         = rnd_req();
    payload[1] = p1;
    payload[3] = rnd_req();
    want[1]    = 1'b1;
    want[3]    = 1'b1;
    acc_qready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        want[0]    = 1'b1;
        payload[0] = rnd_req();
      end
      drive_check();
      chk("bp_req_stable", acc_req_o, p1);
      chk("bp_qready_low", core_qready_o, 0);
      advance();
    end
    acc_qready_i = 1'b1;
    drive_check();
    chk("bp_release", core_qready_o, 4'b0010);
    advance();
    drive_check();
    chk("bp_next", core_qready_o, 4'b1000);
    advance();
    drive_check();
    chk("bp_then0", core_qready_o, 4'b0001);
    advance();
    drain();

    // Full boundary: four outstanding, then one response.
    for (int i = 0; i < N; i++) begin
      want[i]    = 1'b1;
      payload[i] = rnd_req();
    end
    acc_qready_i = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    want[0]    = 1'b1;
    payload[0] = rnd_req();
    drive_check();
    chk("full_qvalid", acc_qvalid_o, 0);
    chk("full_qready", core_qready_o, 0);
    advance();
    acc_pvalid_i  = 1'b1;
    core_pready_i = '1;
    acc_resp_i    = rnd_resp();
    drive_check();
    chk("full_pop_no_push", acc_qvalid_o, 0);
    chk("full_pop", acc_pready_o, 1);
    advance();
    acc_pvalid_i = 1'b0;
    drive_check();
    chk("full_regrant", core_qready_o, 4'b0001);
    advance();
    drain();

    // Response stall and routing for cores 0, 2, 1.
    acc_qready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      want[order[k]]    = 1'b1;
      payload[order[k]] = rnd_req();
      cycle();
    end
    acc_qready_i  = 1'b0;
    acc_pvalid_i  = 1'b1;
    core_pready_i = 4'b1110;
    acc_resp_i    = rnd_resp();
    for (int k = 0; k < 3; k++) begin
      drive_check();
      chk("stall_pready", acc_pready_o, 0);
      chk("stall_pvalid", core_pvalid_o, 4'b0001);
      advance();
    end
    core_pready_i = '1;
    for (int k = 0; k < 3; k++) begin
      acc_resp_i = rnd_resp();
      drive_check();
      chk("route_order", core_pvalid_o, 1 << order[k]);
      advance();
    end
    acc_pvalid_i = 1'b0;

    // Reset with two requests in flight; arbitration restarts at core 0.
    acc_qready_i = 1'b1;
    want[3]      = 1'b1;
    payload[3]   = rnd_req();
    cycle();
    want[0]      = 1'b1;
    payload[0]   = rnd_req();
    cycle();
    chk("mid_busy", busy_o, 1);
    do_reset();
    want[0]      = 1'b1;
    want[1]      = 1'b1;
    payload[0]   = rnd_req();
    payload[1]   = rnd_req();
    acc_qready_i = 1'b1;
    drive_check();
    chk("rst_first_grant", core_qready_o, 4'b0001);
    advance();
    cycle();
    drain();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!want[i] && $urandom_range(2) == 0) begin
          want[i]    = 1'b1;
          payload[i] = rnd_req();
        end
      end
      acc_qready_i  = ($urandom_range(1) == 1);
      acc_pvalid_i  = (m_q.size() != 0) && ($urandom_range(1) == 1);
      core_pready_i = 4'($urandom);
      acc_resp_i    = rnd_resp();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
